// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one UART transmitter between N_REQ byte sources, with message lock.
// Latency: accept in cycle T (req_ready combinational), start pulse at T+1, next accept >= end+1+GAP_CYCLES.
// Backpressure: req_ready only in IDLE; while locked only the owning requester can be accepted.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   req_valid/data/last   per-requester byte offer (data of requester i in [8i+7:8i])
//   req_ready             one-hot accept strobe, transfer on valid&ready
//   uart_data_tx          latched byte, stable from accept to next accept
//   uart_start_transmit   one-cycle start pulse to the UART
//   uart_end_transmit     one-cycle end pulse from the UART
//   busy, grant_id, locked  status
module uart_tx_arbiter #(
    parameter  int N_REQ      = 4,
    parameter  int GAP_CYCLES = 1,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           uart_data_tx,
    output logic                 uart_start_transmit,
    input  logic                 uart_end_transmit,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 locked
);

    // Gap counter must stay at least one bit wide even when no gap is configured.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_END = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic            win_vld;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;

    // Winner selection. While a message is open only its owner is eligible;
    // otherwise scan starting one past the last grant so every source gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_id  = grant_id;
        cand    = grant_id;
        if (locked) begin
            win_vld = req_valid[grant_id];
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = IDW'((int'(grant_id) + k) % N_REQ);
                if (!win_vld && req_valid[cand]) begin
                    win_vld = 1'b1;
                    win_id  = cand;
                end
            end
        end
    end

    // Accept strobe is the only output with a path from req_valid; held off during reset.
    always_comb begin
        req_ready = '0;
        if (reset && (state == IDLE) && win_vld) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= IDLE;
            uart_data_tx        <= 8'h00;
            uart_start_transmit <= 1'b0;
            busy                <= 1'b0;
            grant_id            <= IDW'(N_REQ - 1);
            locked              <= 1'b0;
            gap_cnt             <= '0;
        end else begin
            uart_start_transmit <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        uart_data_tx        <= req_data[8*win_id +: 8];
                        locked              <= ~req_last[win_id];
                        grant_id            <= win_id;
                        uart_start_transmit <= 1'b1;
                        busy                <= 1'b1;
                        state               <= START;
                    end
                end
                START: begin
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    // End pulses outside this state are dropped, never remembered.
                    if (uart_end_transmit) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: randomized and directed stimulus against a timeline reference model of the arbiter.
// Latency: model tracks accept/start/end/gap cycles as plain cycle numbers.
// Backpressure: sources hold each byte until accepted; valids may drop at random.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 3;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [8*N-1:0]     req_data;
    logic [N-1:0]       req_last;
    logic [N-1:0]       req_ready;
    logic [7:0]         uart_data_tx;
    logic               uart_start_transmit;
    logic               uart_end_transmit;
    logic               busy;
    logic [IDW-1:0]     grant_id;
    logic               locked;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_data            (req_data),
        .req_last            (req_last),
        .req_ready           (req_ready),
        .uart_data_tx        (uart_data_tx),
        .uart_start_transmit (uart_start_transmit),
        .uart_end_transmit   (uart_end_transmit),
        .busy                (busy),
        .grant_id            (grant_id),
        .locked              (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source side: each requester has a queue of {last, byte} still to send.
    logic [8:0] srcq [N][$];
    int         hold [N];
    bit         rand_drop = 1'b0;
    bit         spur_en   = 1'b1;

    // Reference model: a timeline of the current byte rather than a state machine.
    bit         m_inflight  = 1'b0;
    int         m_idle_from = 0;
    int         m_start_cyc = -1;
    int         m_ptr       = N - 1;
    bit         m_lock      = 1'b0;
    logic [7:0] m_byte      = 8'h00;
    int         end_due     = -1;
    int         last_end    = -1;
    bit         gap_chk_en  = 1'b0;
    int         log_id [$];
    logic [7:0] log_dat [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight  = 1'b0;
        m_idle_from = 0;
        m_start_cyc = -1;
        m_ptr       = N - 1;
        m_lock      = 1'b0;
        m_byte      = 8'h00;
        end_due     = -1;
        last_end    = -1;
    endtask

    // Called mid-cycle: compare outputs, then advance the model across the coming edge.
    task automatic model_cycle();
        int         w;
        bit         idle;
        logic [N-1:0] exp_rdy;
        logic [8:0] hd;
        idle = !m_inflight && (cyc >= m_idle_from);
        w = -1;
        if (reset && idle) begin
            if (m_lock) begin
                if (req_valid[m_ptr]) w = m_ptr;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("start", 32'(uart_start_transmit), 32'(cyc == m_start_cyc));
        check_eq("busy", 32'(busy), 32'(!idle));
        check_eq("data_tx", 32'(uart_data_tx), 32'(m_byte));
        check_eq("grant_id", 32'(grant_id), m_ptr);
        check_eq("locked", 32'(locked), 32'(m_lock));
        if (!reset) begin
            model_reset();
        end else begin
            if (uart_end_transmit && m_inflight && cyc > m_start_cyc) begin
                m_inflight  = 1'b0;
                m_idle_from = cyc + 1 + GAP;
                last_end    = cyc;
            end
            if (cyc == m_start_cyc) end_due = cyc + $urandom_range(1, 8);
            if (w >= 0) begin
                hd = srcq[w].pop_front();
                m_byte      = hd[7:0];
                m_lock      = !hd[8];
                m_ptr       = w;
                m_inflight  = 1'b1;
                m_start_cyc = cyc + 1;
                log_id.push_back(w);
                log_dat.push_back(hd[7:0]);
                if (gap_chk_en && last_end >= 0) check_eq("gap", cyc - last_end, GAP + 1);
            end
        end
        cyc++;
    endtask

    task automatic drive_inputs();
        logic [8:0] hd;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && hold[i] == 0 && !(rand_drop && $urandom_range(0, 3) == 0)) begin
                hd = srcq[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = hd[7:0];
                req_last[i]        = hd[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
            if (hold[i] > 0) hold[i]--;
        end
        uart_end_transmit = (cyc == end_due) ||
                            (spur_en && (!m_inflight || cyc == m_start_cyc) && $urandom_range(0, 4) == 0);
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N; i++) n += srcq[i].size();
        if (m_inflight || cyc < m_idle_from) n++;
        return n;
    endfunction

    task automatic drain(input int bound);
        int n = 0;
        while (pending() != 0 && n < bound) begin
            step();
            n++;
        end
        check_eq("drain", pending(), 0);
    endtask

    initial begin
        int n;
        logic [7:0] exp_dat [5];
        int         exp_id  [5];
        reset             = 1'b0;
        req_valid         = '0;
        req_data          = '0;
        req_last          = '0;
        uart_end_transmit = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b1;

        // Contention: every requester holds two bytes; order must rotate from 0.
        for (int i = 0; i < N; i++) begin
            srcq[i].push_back({1'b1, 8'(8'h10 + i)});
            srcq[i].push_back({1'b1, 8'(8'h20 + i)});
        end
        gap_chk_en = 1'b1;
        drain(400);
        gap_chk_en = 1'b0;
        check_eq("rr_count", log_id.size(), 8);
        for (int k = 0; k < 8 && k < log_id.size(); k++) begin
            check_eq("rr_order", log_id[k], k % N);
            check_eq("rr_data", 32'(log_dat[k]), 32'(((k < N) ? 8'h10 : 8'h20) + 8'(k % N)));
        end

        // Single requester.
        log_id.delete();
        log_dat.delete();
        srcq[2].push_back({1'b1, 8'hA5});
        drain(100);
        check_eq("single_id", (log_id.size() > 0) ? log_id[0] : -1, 2);
        check_eq("single_dat", (log_dat.size() > 0) ? 32'(log_dat[0]) : 32'hFFFF, 32'hA5);

        // Lock: requester 1 opens "HI", stalls 50 cycles, requester 0 must wait.
        log_id.delete();
        log_dat.delete();
        srcq[1].push_back({1'b0, 8'h48});
        srcq[1].push_back({1'b1, 8'h49});
        n = 0;
        while (log_id.size() == 0 && n < 50) begin
            step();
            n++;
        end
        hold[1] = 50;
        for (int k = 0; k < 3; k++) srcq[0].push_back({1'b1, 8'(8'hC0 + k)});
        for (int k = 0; k < 45; k++) step();
        check_eq("lock_stall_grants", log_id.size(), 1);
        check_eq("lock_stall_locked", 32'(locked), 32'd1);
        drain(400);
        exp_id  = '{1, 1, 0, 0, 0};
        exp_dat = '{8'h48, 8'h49, 8'hC0, 8'hC1, 8'hC2};
        check_eq("lock_count", log_id.size(), 5);
        for (int k = 0; k < 5 && k < log_id.size(); k++) begin
            check_eq("lock_order", log_id[k], exp_id[k]);
            check_eq("lock_data", 32'(log_dat[k]), 32'(exp_dat[k]));
        end

        // Reset while waiting for the end of a locked message byte.
        log_id.delete();
        log_dat.delete();
        srcq[2].push_back({1'b0, 8'h31});
        srcq[2].push_back({1'b0, 8'h32});
        srcq[2].push_back({1'b1, 8'h33});
        n = 0;
        while (!(m_lock && m_inflight && cyc > m_start_cyc) && n < 100) begin
            step();
            n++;
        end
        check_eq("pre_rst_locked", 32'(locked), 32'd1);
        reset = 1'b0;
        srcq[2].delete();
        srcq[0].push_back({1'b1, 8'h5A});
        srcq[3].push_back({1'b1, 8'h3C});
        step();
        reset = 1'b1;
        log_id.delete();
        log_dat.delete();
        drain(200);
        check_eq("rst_win_first", (log_id.size() > 0) ? log_id[0] : -1, 0);
        check_eq("rst_win_second", (log_id.size() > 1) ? log_id[1] : -1, 3);

        // Randomized traffic: multi-byte messages, random valid drops and stalls.
        rand_drop = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                int len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) srcq[i].push_back({1'(b == len - 1), 8'($urandom)});
                if ($urandom_range(0, 2) == 0) hold[i] = $urandom_range(1, 20);
            end
            drain(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `reflet_uart_uart` transmitter between `N_REQ` byte sources, such as a debug message sender, a CPU UART peripheral and a status reporter. Each source offers bytes through a valid/ready handshake. The arbiter latches the winning byte, sequences `start_transmit`/`end_transmit` on the UART and inserts a configurable idle gap between bytes. A per-byte `last` flag lets a source lock the transmitter for a whole multi-byte message, so messages from different sources never interleave.

## Interface
- `N_REQ`, 4: number of requesters, ≥1.
- `GAP_CYCLES`, 1: idle clk cycles after `end_transmit` before the next grant, ≥0.
- `IDW`, derived: `N_REQ>1 ? $clog2(N_REQ) : 1`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `req_valid`  in  N_REQ  requester i has a byte to send.
- `req_data`  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
- `req_last`  in  N_REQ  byte of requester i ends its message.
- `req_ready`  out  N_REQ  one-hot, one-cycle accept strobe; the transfer occurs when `valid&ready`.
- `uart_data_tx`  out  8  latched byte, to UART `data_tx`.
- `uart_start_transmit`  out  1  one-cycle pulse, to UART.
- `uart_end_transmit`  in  1  one-cycle pulse from UART when the byte is fully shifted out.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  IDW  index of the current/last granted requester.
- `locked`  out  1  high while a message is open (last accepted byte had `last=0`).

## Operation
- **States:**
  - **IDLE:** choose a winner; if one exists, assert `req_ready[w]`, latch `req_data[w]` into `uart_data_tx`, latch `req_last[w]`, set `grant_id=w`, go to START.
  - **START:** assert `uart_start_transmit` for this cycle only, go to WAIT_END.
  - **WAIT_END:** wait for `uart_end_transmit`. On it, go to GAP if `GAP_CYCLES>0`, else IDLE.
  - **GAP:** count `GAP_CYCLES` cycles, then go to IDLE.
- **Winner selection when not locked:**
  - Round-robin starting at `grant_id+1` (mod `N_REQ`), first i with `req_valid[i]`.
  - Reset sets `grant_id=N_REQ-1`, so requester 0 has first priority.
- **Winner selection when locked:**
  - Only requester `grant_id` is eligible; other valids are ignored.
  - If it is not valid, the arbiter stays in IDLE indefinitely. There is no timeout.
- **Lock:** `locked` is set when the accepted byte has `last=0` and cleared when it has `last=1`. It is updated in the accept cycle.
- **Byte stability:** `uart_data_tx` holds its value from the accept until the next accept. It is never changed while busy.
- **Ignored `uart_end_transmit`:** ignored in IDLE, START and GAP. It is not queued.
- **`req_ready`:** never asserted to a requester whose `req_valid` is low. At most one bit is high.
- **Requester sources:** requesters may change data/valid freely while not accepted. No combinational path from `req_valid` to any output other than `req_ready`.

## Timing
- **Reset values:** state IDLE, `req_ready=0`, `uart_data_tx=8'h00`, `uart_start_transmit=0`, `busy=0`, `grant_id=N_REQ-1`, `locked=0`, gap counter 0.
- **Reset mid-operation:** the same values apply on the next edge. The byte in flight is abandoned and the UART is reset by the same `reset`.
- **Accept:** cycle T, in IDLE with a valid requester, `req_ready` high (combinational from state and `req_valid`).
- **Start:** `uart_start_transmit` high in cycle T+1. `busy` high from T+1.
- **End:** end pulse in cycle E. The state is GAP during E+1..E+`GAP_CYCLES`, and IDLE at E+1+`GAP_CYCLES`.
- **Next accept:** earliest possible at cycle E+1+`GAP_CYCLES`.
- **Minimum byte-to-byte spacing:** UART frame time + `GAP_CYCLES` + 2 cycles.
- **Gap counter width:** `$clog2(GAP_CYCLES+1)`. No wrap is possible because it is cleared on entry to GAP.
- **Round-robin pointer:** wraps from `N_REQ-1` to 0.

## Test plan
- **Single requester:** `N_REQ=4`, requester 2 sends 8'hA5 with last=1 → `req_ready=4'b0100` at T, start pulse at T+1, `uart_data_tx=8'hA5`, tx line shows 0xA5, `busy` falls `GAP_CYCLES`+1 after end.
- **Contention:** all four valid and last=1, held → grant order 0,1,2,3,0. Exactly one `req_ready` per byte. No two start pulses without an intervening end.
- **Lock:** requester 1 sends "HI" (last=0 then last=1) while requester 0 is continuously valid → bytes 'H','I' back-to-back from 1, then 0 is granted. During the lock, requester 1 drops valid for 50 cycles → the arbiter idles and does not grant 0.
- **Gap:** `GAP_CYCLES=0` and `GAP_CYCLES=5` → next accept exactly 1 and 6 cycles after the end pulse.
- **Spurious end:** `uart_end_transmit` forced high in IDLE and in GAP → no state change, no extra `req_ready`.
- **Reset mid-operation:** reset asserted in WAIT_END with `locked=1` → next cycle all outputs at reset values. After release, requester 0 wins against 3.
